// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: receiver FSM state encoding, frame
// width and the idle level of the serial line.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchroniser for asynchronous inputs. Both stages reset to
// RESET_VAL so a line that idles at a known level does not look like an edge
// when reset is released.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input
//   q     - synchronised output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 asynchronous serial receiver, LSB first, idle-high line. Bits are
// sampled mid-bit using a CLKS_PER_BIT divider; each good byte lands in a
// single-entry valid/ready output buffer.
// Ports:
//   clk       - system clock
//   rst_n     - asynchronous active-low reset
//   rx        - serial input, asynchronous to clk
//   data      - received byte, valid while valid is high
//   valid     - output buffer full
//   ready     - consumer takes data on valid && ready
//   frame_err - one-cycle pulse: stop bit sampled low
//   overrun   - one-cycle pulse: good byte dropped, buffer was full
//   busy      - receiver not idle
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(UART_DATA_BITS);
  // The start check lands on the bit centre; all later samples are a whole
  // bit period apart, so they stay centred too.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (UART_IDLE_LEVEL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  uart_rx_state_t              state_reg, state_next;
  logic [CW-1:0]               cnt_reg, cnt_next;
  logic [IW-1:0]               idx_reg, idx_next;
  logic [UART_DATA_BITS-1:0]   shift_reg, shift_next;
  logic [7:0]                  data_reg, data_next;
  logic                        valid_reg, valid_next;
  logic                        frame_err_reg, frame_err_next;
  logic                        overrun_reg, overrun_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    data_next      = data_reg;
    // An accept empties the buffer unless a new byte reloads it below.
    valid_next     = valid_reg && !ready;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rx_s != UART_IDLE_LEVEL) begin
          state_next = START;
          cnt_next   = '0;
        end
      end

      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          idx_next = '0;
          // Line back high at mid-start: a glitch, not a frame.
          state_next = (rx_s == UART_IDLE_LEVEL) ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          // Shift in from the top; after all bits the first one sits at bit 0.
          shift_next = {rx_s, shift_reg[UART_DATA_BITS-1:1]};
          if (idx_reg == IDX_LAST) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s == UART_IDLE_LEVEL) begin
            // Returning straight to IDLE lets a start bit follow immediately.
            state_next = IDLE;
            if (!valid_reg || ready) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end else begin
              overrun_next = 1'b1;
            end
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      BREAK: begin
        // Hold here until the line recovers so a stuck-low line does not
        // produce a stream of frame errors.
        if (rx_s == UART_IDLE_LEVEL) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Frames are driven bit by bit on rx; the
// expected output timing is computed from the frame start edge (e0) and the
// bit period, and consumed bytes are compared against the bytes sent.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int T   = 16;
  localparam int H   = T / 2;
  localparam int LAT = 2 + H + 9 * T;   // e0 -> stop sample edge

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc == n.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction monitor: bytes taken by the consumer and flag pulse counts.
  logic [7:0] acc_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  always @(negedge clk) begin
    if (valid && ready) acc_q.push_back(data);
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Wait until rising edge n has happened (returns on a falling edge).
  task automatic wait_edge(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Re-align to 1 time unit after a rising edge.
  task automatic sync_pos();
    @(posedge clk);
    #1;
  endtask

  // Drive one 10-bit frame. Called and returns 1 unit after a rising edge,
  // so consecutive calls are back-to-back; rx is left at the stop level.
  task automatic send_bits(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    $display("frame 0x%02h stop=%0b e0=%0d", b, stop_bit, cyc + 1);
    for (int k = 0; k < 10; k++) begin
      rx = fr[k];
      repeat (T) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int unsigned e0, e1, s2, r;
  int          fe0, ov0, acc0, gap;
  logic [7:0]  exp_q[$];
  logic [7:0]  b;

  initial begin
    // ---------------- reset values ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (4) sync_pos();

    // ---------------- 0x4A, ready high ----------------
    ready = 1'b1;
    e0 = cyc + 1;
    fork
      send_bits(8'h4A, 1'b1);
      begin
        wait_edge(e0 + 1);   check("t1_busy_e0+1", busy, 0);
        wait_edge(e0 + 2);   check("t1_busy_e0+2", busy, 1);
        wait_edge(e0 + LAT - 1); check("t1_valid_early", valid, 0);
        wait_edge(e0 + LAT);
        check("t1_valid", valid, 1);
        check("t1_data", data, 8'h4A);
        check("t1_frame_err", frame_err, 0);
        check("t1_overrun", overrun, 0);
        wait_edge(e0 + LAT + 1); check("t1_valid_pulse", valid, 0);
      end
    join
    repeat (T) sync_pos();

    // ---------------- 4-cycle low glitch ----------------
    fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_q.size();
    e0 = cyc + 1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    wait_edge(e0 + 2 + H - 1); check("t2_busy_start", busy, 1);
    wait_edge(e0 + 2 + H + 1); check("t2_busy_idle", busy, 0);
    repeat (12 * T) sync_pos();
    check("t2_no_byte", acc_q.size(), acc0);
    check("t2_no_fe", fe_cnt, fe0);
    check("t2_no_ov", ov_cnt, ov0);

    // ---------------- 0x55, stop bit low, line held low ----------------
    fe0 = fe_cnt; acc0 = acc_q.size();
    e0 = cyc + 1;
    fork
      begin
        send_bits(8'h55, 1'b0);
        repeat (40 * T) @(posedge clk);
        #1;
      end
      begin
        wait_edge(e0 + LAT);
        check("t3_frame_err", frame_err, 1);
        check("t3_valid", valid, 0);
        wait_edge(e0 + LAT + 1); check("t3_fe_pulse", frame_err, 0);
      end
    join
    check("t3_busy_break", busy, 1);
    rx = 1'b1;
    r = cyc;
    wait_edge(r + 2); check("t3_busy_hold", busy, 1);
    wait_edge(r + 3); check("t3_busy_release", busy, 0);
    repeat (T) sync_pos();
    check("t3_fe_count", fe_cnt - fe0, 1);
    check("t3_no_byte", acc_q.size(), acc0);

    // ---------------- ready low, 0x11 then 0x22 back-to-back ----------------
    ready = 1'b0;
    ov0 = ov_cnt; acc0 = acc_q.size();
    e0 = cyc + 1;
    e1 = e0 + 10 * T;
    fork
      begin
        send_bits(8'h11, 1'b1);
        send_bits(8'h22, 1'b1);
      end
      begin
        wait_edge(e0 + LAT);
        check("t4_valid1", valid, 1);
        check("t4_data1", data, 8'h11);
        wait_edge(e1 + LAT);
        check("t4_overrun", overrun, 1);
        check("t4_data_held", data, 8'h11);
        check("t4_valid_held", valid, 1);
        wait_edge(e1 + LAT + 1); check("t4_ov_pulse", overrun, 0);
      end
    join
    ready = 1'b1;
    repeat (3) sync_pos();
    ready = 1'b0;
    repeat (2) sync_pos();
    check("t4_one_byte", acc_q.size() - acc0, 1);
    if (acc_q.size() > acc0) check("t4_byte", acc_q[acc0], 8'h11);
    check("t4_valid_drained", valid, 0);
    check("t4_ov_count", ov_cnt - ov0, 1);

    // ---------------- accept on the edge 0x33 completes ----------------
    ov0 = ov_cnt; acc0 = acc_q.size();
    e0 = cyc + 1;
    s2 = e0 + 10 * T + LAT;
    fork
      begin
        send_bits(8'h44, 1'b1);
        send_bits(8'h33, 1'b1);
      end
      begin
        wait_edge(s2 - 2);
        sync_pos();           // 1 unit after edge s2-1
        ready = 1'b1;
        sync_pos();           // 1 unit after edge s2
        ready = 1'b0;
        check("t5_valid", valid, 1);
        check("t5_data", data, 8'h33);
        check("t5_no_overrun", overrun, 0);
      end
    join
    check("t5_ov_count", ov_cnt, ov0);
    check("t5_one_byte", acc_q.size() - acc0, 1);
    if (acc_q.size() > acc0) check("t5_byte", acc_q[acc0], 8'h44);
    check("t5_still_valid", valid, 1);

    // ---------------- reset mid-DATA of 0xFF ----------------
    rx = 1'b0;
    repeat (T) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * T) @(posedge clk);
    #1;
    check("t6_busy_before", busy, 1);
    rst_n = 1'b0;
    #2;
    check("t6_rst_data", data, 0);
    check("t6_rst_valid", valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_fe", frame_err, 0);
    check("t6_rst_ov", overrun, 0);
    repeat (3) sync_pos();
    rst_n = 1'b1;
    repeat (2 * T) sync_pos();
    check("t6_idle_after", busy, 0);
    acc0 = acc_q.size();
    ready = 1'b1;
    send_bits(8'h0F, 1'b1);
    repeat (2 * T) sync_pos();
    check("t6_one_byte", acc_q.size() - acc0, 1);
    if (acc_q.size() > acc0) check("t6_byte", acc_q[acc0], 8'h0F);

    // ---------------- random frames, random idle gaps ----------------
    fe0 = fe_cnt; ov0 = ov_cnt; acc0 = acc_q.size();
    exp_q.delete();
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      gap = $urandom_range(0, 2 * T);
      send_bits(b, 1'b1);
      exp_q.push_back(b);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    repeat (2 * T) sync_pos();
    check("rnd_count", acc_q.size() - acc0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (acc0 + i < acc_q.size())
        check($sformatf("rnd_byte%0d", i), acc_q[acc0 + i], exp_q[i]);
    end
    check("rnd_no_fe", fe_cnt, fe0);
    check("rnd_no_ov", ov_cnt, ov0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, LSB first, idle-high line, and the receive counterpart of the team's UART transmitter. It synchronises the external `rx` pin and detects a start bit. Each bit is sampled at its mid-point using a programmable clocks-per-bit divider. Each good byte is presented on a single-entry valid/ready output buffer toward the consumer logic, with frame-error and overrun flags.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit (T). Legal range is 4 to 65535.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset. One clock, asynchronous active-low reset (fixed).
- `rx` input 1: serial line. Asynchronous to `clk`; idles high.
- `data` output 8: received byte. Valid while `valid` is high.
- `valid` output 1: output buffer full.
- `ready` input 1: consumer accepts `data` when `valid && ready`.
- `frame_err` output 1: one-cycle pulse when the stop bit samples 0.
- `overrun` output 1: one-cycle pulse when a good byte is dropped because the buffer is full.
- `busy` output 1: FSM is not in IDLE.

## Operation
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `overrun`=0, `busy`=0. Both synchroniser flops reset to 1. FSM resets to IDLE with counters at 0.
- `rx` passes through a 2-flop synchroniser to produce `rx_s`. The FSM uses only `rx_s`.
- H = floor(T/2). The bit counter runs 0..T-1. The bit index runs 0..7.
- **IDLE**: on `rx_s`=0, go to START with the counter cleared.
- **START**: when the counter reaches H-1, re-sample `rx_s`.
  - If `rx_s`=1, it is a false start. Return to IDLE with no flag.
  - If `rx_s`=0, go to DATA with the counter and index cleared.
- **DATA**: when the counter reaches T-1, shift `rx_s` into bit[index] (LSB first) and clear the counter. After index 7, go to STOP.
- **STOP**: when the counter reaches T-1, sample `rx_s`.
  - If `rx_s`=1 and the buffer is empty, or is being emptied this cycle, load `data` and set `valid`.
  - If `rx_s`=1 and the buffer is full and not being read, pulse `overrun`, keep the old `data`, and drop the new byte.
  - If `rx_s`=0, pulse `frame_err`, load nothing, and go to BREAK.
  - In both good-stop cases, return to IDLE.
- **BREAK**: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from retriggering continuously.
- Output buffer rules:
  - `valid` clears on the edge where `valid && ready`.
  - Simultaneous accept and new byte: the new byte loads and `valid` stays 1. No overrun.
  - `ready` while `valid`=0 is ignored.
- Reset asserted mid-frame aborts immediately to the reset values. After release, the receiver waits in IDLE for the next falling `rx_s`.

## Timing
- Let e0 be the first clock edge that captures `rx`=0 into the synchroniser.
- START is entered at e0+2. The start mid-check happens at edge e0+2+H.
- Data bit i is sampled at edge e0+2+H+(i+1)·T. The stop bit is sampled at edge e0+2+H+9T.
- `valid` (or `frame_err`/`overrun`) is high from edge e0+2+H+9T. With T=16 that is e0+154.
- Flag pulses last exactly one cycle.
- `busy` is high from e0+2 until the IDLE return. In BREAK, it stays high until `rx_s` rises.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. IDLE is re-entered at the stop sample, with no extra idle bit required.
- Total sampling-point error tolerance is about ±H/T of a bit over 10 bits.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_rx_state_t` (IDLE, START, DATA, STOP, BREAK);
  - the constants `UART_DATA_BITS`=8 and `UART_IDLE_LEVEL`=1.
- The counter width is `$clog2(CLKS_PER_BIT)`.
- One natural sub-module: `sync_2ff`, a generic 2-flop synchroniser with a reset value parameter. It is reusable for other async inputs.
- FSM and datapath live in a single always_ff plus an always_comb next-state block.

## Test plan
- T=16, send 0x4A framed correctly with `ready`=1 → `valid` pulses 1 cycle at e0+154 with `data`=0x4A; `frame_err`=`overrun`=0.
- Low glitch of 4 cycles on `rx` in idle → no state beyond START, `busy` returns to 0, no outputs.
- Send 0x55 with stop bit forced 0, then hold `rx` low 40 bit-times → single `frame_err` pulse, `valid`=0, `busy` stays 1 until `rx` returns high.
- `ready`=0, send 0x11 then 0x22 back-to-back → `data`=0x11 held with `valid`=1, one `overrun` pulse at the second stop sample. Raising `ready` then yields 0x11 only.
- `ready` asserted on the exact edge the next byte 0x33 completes → `data`=0x33, `valid` stays 1, no `overrun`.
- Assert `rst_n`=0 mid-DATA of 0xFF, release, then send 0x0F → outputs at reset values during reset; next `data`=0x0F with no spurious `valid`.
